// File: rtl/aes_round_ctrl.sv
// AES round sequencer: drives load/round/key-step strobes for an external datapath.
// Optional block counter output enabled by defining AES_ROUND_CTRL_BLK_CNT_EN.
module aes_round_ctrl #(
  parameter int NUM_ROUNDS   = 10,
  parameter int ROUND_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        load_en,
  output logic        key_load,
  output logic        round_en,
  output logic        key_step,
  output logic [3:0]  round_idx,
  output logic        skip_mixcol,
  output logic        busy,
  output logic        out_valid,
`ifdef AES_ROUND_CTRL_BLK_CNT_EN
  output logic [15:0] blk_count,
`endif
  input  logic        out_ready
);

  localparam int              CW       = (ROUND_CYCLES > 1) ? $clog2(ROUND_CYCLES) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(ROUND_CYCLES - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [3:0]      IDX_LAST = 4'(NUM_ROUNDS);

  if (NUM_ROUNDS != 10 && NUM_ROUNDS != 12 && NUM_ROUNDS != 14) begin : g_bad_rounds
    $error("aes_round_ctrl: NUM_ROUNDS must be 10, 12 or 14");
  end
  if (ROUND_CYCLES < 1) begin : g_bad_cycles
    $error("aes_round_ctrl: ROUND_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ROUND, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    idx_q, idx_d;
  logic          in_ready_q, in_ready_d;
  logic          load_q, load_d;
  logic          step_q, step_d;
  logic          skip_q, skip_d;
  logic          busy_q, busy_d;
  logic          out_valid_q, out_valid_d;
  logic          out_hs;

  assign out_hs = out_valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        idx_d = 4'd0;
        cnt_d = '0;
        if (in_valid && in_ready_q) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        state_d = S_ROUND;
        idx_d   = 4'd1;
        cnt_d   = '0;
      end
      S_ROUND: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DONE: begin
        if (out_hs) begin
          state_d = S_IDLE;
          idx_d   = 4'd0;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = 4'd0;
        cnt_d   = '0;
      end
    endcase

    // Outputs are decoded from the next state so every strobe comes straight off a flop.
    in_ready_d  = (state_d == S_IDLE);
    load_d      = (state_d == S_LOAD);
    step_d      = (state_d == S_ROUND) && (cnt_d == CNT_LAST);
    skip_d      = (state_d == S_ROUND) && (idx_d == IDX_LAST);
    busy_d      = (state_d == S_LOAD) || (state_d == S_ROUND);
    out_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= 4'd0;
      in_ready_q  <= 1'b0;
      load_q      <= 1'b0;
      step_q      <= 1'b0;
      skip_q      <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      load_q      <= load_d;
      step_q      <= step_d;
      skip_q      <= skip_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign load_en     = load_q;
  assign key_load    = load_q;
  assign round_en    = step_q;
  assign key_step    = step_q;
  assign round_idx   = idx_q;
  assign skip_mixcol = skip_q;
  assign busy        = busy_q;
  assign out_valid   = out_valid_q;

`ifdef AES_ROUND_CTRL_BLK_CNT_EN
  logic [15:0] blk_count_q, blk_count_d;

  always_comb begin
    blk_count_d = blk_count_q;
    if (out_hs) begin
      blk_count_d = blk_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_count_q <= 16'd0;
    end else begin
      blk_count_q <= blk_count_d;
    end
  end

  assign blk_count = blk_count_q;
`endif

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: two instances (10x1 and 14x3) share stimulus; each is
// checked every cycle against a timeline model, plus hand-computed timing points.
module tb_aes_round_ctrl;

  localparam int M_RST  = 0;
  localparam int M_IDLE = 1;
  localparam int M_BUSY = 2;
  localparam int M_DONE = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int NR = (g == 0) ? 10 : 14;
    localparam int RC = (g == 0) ? 1 : 3;

    logic        in_ready, load_en, key_load, round_en, key_step;
    logic        skip_mixcol, busy, out_valid;
    logic [3:0]  round_idx;
    logic [11:0] act;
`ifdef AES_ROUND_CTRL_BLK_CNT_EN
    logic [15:0] blk_count;
`endif

    aes_round_ctrl #(.NUM_ROUNDS(NR), .ROUND_CYCLES(RC)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .load_en(load_en), .key_load(key_load), .round_en(round_en), .key_step(key_step),
      .round_idx(round_idx), .skip_mixcol(skip_mixcol), .busy(busy), .out_valid(out_valid),
`ifdef AES_ROUND_CTRL_BLK_CNT_EN
      .blk_count(blk_count),
`endif
      .out_ready(out_ready)
    );

    assign act = {in_ready, load_en, key_load, round_en, key_step, skip_mixcol,
                  busy, out_valid, round_idx};

    // Model: mode plus t = cycles since the accepting edge (t=1 is the load cycle).
    int mode = M_RST;
    int t = 0;
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        mode <= M_RST;
        t    <= 0;
      end else begin
        case (mode)
          M_RST:  mode <= M_IDLE;
          M_IDLE: if (in_valid) begin mode <= M_BUSY; t <= 1; end
          M_BUSY: if (t == 1 + NR * RC) mode <= M_DONE; else t <= t + 1;
          M_DONE: if (out_ready) mode <= M_IDLE;
          default: mode <= M_RST;
        endcase
      end
    end

    int n_round = 0;
    int n_load = 0;
    bit done_seen = 1'b0;
    always @(negedge clk) begin
      int r;
      logic [11:0] e;
      logic bsy, ld, re, sk;
      logic [3:0] ix;
      bsy = (mode == M_BUSY);
      r   = (t >= 2) ? (t - 2) / RC + 1 : 0;
      ld  = bsy && (t == 1);
      re  = bsy && (t >= 2) && ((t - 1) % RC == 0);
      sk  = bsy && (r == NR);
      ix  = bsy ? 4'(r) : ((mode == M_DONE) ? 4'(NR) : 4'd0);
      e   = {mode == M_IDLE, ld, ld, re, re, sk, bsy, mode == M_DONE, ix};
      chk($sformatf("outs[%0d]", g), int'(act), int'(e));
      if (mode == M_RST || mode == M_IDLE) begin
        n_round = 0; n_load = 0; done_seen = 1'b0;
      end else if (mode == M_BUSY) begin
        n_round += int'(round_en);
        n_load  += int'(load_en);
      end else if (!done_seen) begin
        done_seen = 1'b1;
        chk($sformatf("round_en count[%0d]", g), n_round, NR);
        chk($sformatf("load_en count[%0d]", g), n_load, 1);
      end
    end
  end

  task automatic wait_idle();
    int i;
    i = 0;
    while (i < 200 && !(g_dut[0].in_ready && g_dut[1].in_ready)) begin
      @(negedge clk);
      i++;
    end
    chk("idle reached", int'(g_dut[0].in_ready && g_dut[1].in_ready), 1);
  endtask

  // Both instances idle on entry; accept at the next edge (edge 0) and pin timing.
  task automatic block_timing();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int c = 1; c <= 46; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (c == 1) begin
        chk("s1 load_en", int'(g_dut[0].load_en), 1);
        chk("s1 key_load", int'(g_dut[0].key_load), 1);
        chk("s1 idx0", int'(g_dut[0].round_idx), 0);
      end
      if (c >= 2 && c <= 11) begin
        chk("s1 round_en", int'(g_dut[0].round_en), 1);
        chk("s1 idx", int'(g_dut[0].round_idx), c - 1);
        chk("s1 skip", int'(g_dut[0].skip_mixcol), int'(c == 11));
      end
      if (c == 12) chk("s1 out_valid", int'(g_dut[0].out_valid), 1);
      if (c == 12) chk("s1 in_ready low", int'(g_dut[0].in_ready), 0);
      if (c == 13) chk("s1 in_ready back", int'(g_dut[0].in_ready), 1);
      if (c == 4)  chk("s4 round_en c4", int'(g_dut[1].round_en), 1);
      if (c == 5)  chk("s4 round_en c5", int'(g_dut[1].round_en), 0);
      if (c == 40) chk("s4 skip c40", int'(g_dut[1].skip_mixcol), 0);
      if (c == 41) chk("s4 skip c41", int'(g_dut[1].skip_mixcol), 1);
      if (c == 41) chk("s4 idx c41", int'(g_dut[1].round_idx), 14);
      if (c == 43) chk("s4 round_en c43", int'(g_dut[1].round_en), 1);
      if (c == 43) chk("s4 out_valid c43", int'(g_dut[1].out_valid), 0);
      if (c == 44) chk("s4 out_valid c44", int'(g_dut[1].out_valid), 1);
    end
  endtask

  task automatic run_one_block();
    wait_idle();
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    wait_idle();
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready after reset", int'(g_dut[0].in_ready), 1);

    // Scenarios 1 and 4: single block with exact timing on both configurations
    block_timing();

    // Scenario 2: backpressure on the 10x1 instance
    wait_idle();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (n < 40 && !g_dut[0].out_valid) begin
      @(negedge clk);
      n++;
    end
    chk("s2 out_valid seen", int'(g_dut[0].out_valid), 1);
    repeat (5) begin
      @(negedge clk);
      chk("s2 hold out_valid", int'(g_dut[0].out_valid), 1);
      chk("s2 hold in_ready", int'(g_dut[0].in_ready), 0);
      chk("s2 hold round_en", int'(g_dut[0].round_en), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("s2 release in_ready", int'(g_dut[0].in_ready), 1);
    chk("s2 release out_valid", int'(g_dut[0].out_valid), 0);

    // Scenario 3: in_valid held across two back-to-back blocks
    wait_idle();
    in_valid = 1'b1;
    n = 0;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      n += int'(g_dut[0].round_en);
      if (c == 13) chk("s3 no early load", int'(g_dut[0].load_en), 0);
      if (c == 14) chk("s3 second load_en", int'(g_dut[0].load_en), 1);
      if (c == 25) chk("s3 second out_valid", int'(g_dut[0].out_valid), 1);
    end
    in_valid = 1'b0;
    chk("s3 round_en total", n, 20);

    // Scenario 5: asynchronous reset during round 5
    wait_idle();
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (n < 40 && g_dut[0].round_idx != 4'd5) begin
      @(negedge clk);
      n++;
    end
    chk("s5 reached round 5", int'(g_dut[0].round_idx), 5);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("s5 async clear 0", int'(g_dut[0].act), 0);
    chk("s5 async clear 1", int'(g_dut[1].act), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("s5 in_ready after release", int'(g_dut[0].in_ready && g_dut[1].in_ready), 1);
    block_timing();

    // Random traffic including occasional asynchronous resets
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b0;

`ifdef AES_ROUND_CTRL_BLK_CNT_EN
    // Scenario 6: block counter and its wrap
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("s6 count reset", int'(g_dut[0].blk_count), 0);
    repeat (3) run_one_block();
    chk("s6 count 3", int'(g_dut[0].blk_count), 3);
    chk("s6 count 3 inst1", int'(g_dut[1].blk_count), 3);
    force g_dut[0].u_dut.blk_count_q = 16'hFFFF;
    @(negedge clk);
    release g_dut[0].u_dut.blk_count_q;
    @(negedge clk);
    chk("s6 forced", int'(g_dut[0].blk_count), 32'hFFFF);
    run_one_block();
    chk("s6 wrap", int'(g_dut[0].blk_count), 0);
`endif

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
